cpu_dma_bus_sm: RTL
===================

Name: cpu_dma_bus_sm

Overview:
Parametrised CPU-side DMA bus-master state machine for the SDMAC replacement. It arbitrates for the 68030 bus and runs bursts of long or word cycles between the FIFO and memory, in both directions. It handles DSACK port sizing, including a second half-cycle for 16-bit ports, and flushes a partial last word. It adds three things earlier CPU state logic lacks: a configurable burst limit, a DSACK timeout, and bus-error termination.

Parameters:
BURST_MAX, 4, maximum word/long transfers per bus tenure (1..15).
TO_CYCLES, 64, CLK cycles in the data phase before timeout (2..255).
TO_WIDTH, 8, width of the timeout counter.

Ports:
CLK  in  1  system clock, all state on rising edge
RST_  in  1  asynchronous active-low reset
DMAENA  in  1  DMA enabled
DMADIR  in  1  1 = FIFO->memory (write cycles), 0 = memory->FIFO (read cycles)
FIFOEMPTY  in  1  FIFO has no complete long
FIFOFULL  in  1  FIFO full
FLUSHFIFO  in  1  drain the FIFO even if not full
LASTWORD  in  1  FIFO holds only a final partial long
BOEQ3  in  1  byte pointer equals 3
A1  in  1  current address bit 1
BGRANT_  in  1  bus grant, active low
DSACK0_  in  1  data size acknowledge 0, active low
DSACK1_  in  1  data size acknowledge 1, active low
BERR_  in  1  bus error, active low
BREQ_  out  1  bus request, active low
BGACK_  out  1  bus grant acknowledge, active low
AS_  out  1  address strobe, active low
DS_  out  1  data strobe, active low
RW  out  1  1 = read cycle
SIZ  out  2  00 = long, 10 = word
F2CPU  out  1  one-clock pulse: pop FIFO (write direction)
CPU2F  out  1  one-clock pulse: push FIFO (read direction)
INCNO_L  out  1  one-clock pulse: address += 4
INCNO_W  out  1  one-clock pulse: address += 2
DONE  out  1  one-clock pulse when the bus is released normally
ERR  out  1  sticky error flag; cleared when DMAENA is low

Behaviour:
- Reset: state IDLE. BREQ_, BGACK_, AS_ and DS_ are 1. RW = 1, SIZ = 00. All pulse outputs are 0 and ERR = 0. Counters are 0.
- Start condition in IDLE, with DMAENA = 1 and ERR = 0:
  - Write direction (DMADIR = 1): FIFOFULL, or FLUSHFIFO & !FIFOEMPTY, or FLUSHFIFO & LASTWORD.
  - Read direction (DMADIR = 0): !FIFOFULL.
- IDLE -> BREQ when the start condition holds; BREQ_ = 0.
- BREQ -> OWN when BGRANT_ = 0. In OWN, BGACK_ = 0 and BREQ_ = 1; BGACK_ stays 0 until RELEASE.
- OWN -> ADDR on the next clock.
- ADDR (1 clk): AS_ = 0. RW = !DMADIR.
  - SIZ = 10 if A1 = 1, or if LASTWORD & !BOEQ3 in the write direction; otherwise SIZ = 00.
  - The timeout counter clears.
- ADDR -> DATA. In DATA, DS_ = 0, and DSACK/BERR_ are sampled every clock. The timeout counter increments each clock.
- DATA exit priority:
  1. BERR_ = 0 -> ERROR.
  2. Timeout counter = TO_CYCLES-1 -> ERROR.
  3. DSACK1_ = 0 & DSACK0_ = 0 -> TERM (full width).
  4. DSACK1_ = 0 & DSACK0_ = 1 -> TERM16 if SIZ = 00, else TERM.
  5. DSACK1_ = 1 & DSACK0_ = 0 (8-bit port, unsupported) -> ERROR.
  6. Otherwise stay in DATA (wait states).
- TERM (1 clk):
  - AS_ and DS_ are 1.
  - Pulse F2CPU in the write direction or CPU2F in the read direction.
  - Pulse INCNO_L if SIZ = 00, else INCNO_W.
  - The burst counter increments.
- TERM16 (1 clk): AS_ and DS_ are 1, INCNO_W pulses, then -> ADDR with SIZ forced to 10 for the second half. The FIFO strobe is issued only in the TERM that ends the second half.
- After TERM, go to ADDR if all of the following hold; otherwise go to RELEASE:
  - the burst count is below BURST_MAX;
  - DMAENA = 1;
  - the data source/sink is available (write: !FIFOEMPTY | LASTWORD; read: !FIFOFULL);
  - the current cycle was not a LASTWORD partial.
- RELEASE (1 clk): BGACK_ = 1, DONE pulses, burst counter clears, -> IDLE.
- ERROR (1 clk): AS_ and DS_ are 1, ERR is set, there is no FIFO strobe and no address increment, then -> RELEASE. DONE does not pulse on this path. ERR holds until DMAENA = 0.
- DMAENA falling mid-cycle does not abort an active AS_. The current cycle completes, then the block releases the bus.
- BGRANT_ rising after OWN is ignored until RELEASE; the block keeps the bus via BGACK_.
- Asynchronous reset at any point negates all strobes immediately.
- Minimum cycle is 3 clks (ADDR, DATA, TERM). A 16-bit long takes 6 clks.

Decomposition:
- Package cpu_dma_pkg holds:
  - the state enum: IDLE, BREQ, OWN, ADDR, DATA, TERM, TERM16, ERROR, RELEASE;
  - SIZ encodings SIZ_LONG = 00 and SIZ_WORD = 10;
  - DSACK decode constants.
- One sub-module, cpu_dma_timeout: a loadable TO_WIDTH counter with clear, enable and an expiry flag.

Test Plan:
- Write, FIFOFULL = 1, BURST_MAX = 4, 32-bit port (both DSACK low on the first DATA clock): 4 longs, then release. Expect 12 clks from ADDR to RELEASE, 4 F2CPU pulses, 4 INCNO_L pulses, and DONE once.
- Read, 16-bit port (DSACK1_ only), A1 = 0: each long becomes two AS_ cycles, SIZ 00 then 10. Expect 2 INCNO_W pulses per long and one CPU2F per long.
- Flush with LASTWORD = 1 and BOEQ3 = 0: a single cycle with SIZ = 10, one F2CPU pulse, then immediate RELEASE even though the burst count is below BURST_MAX.
- No DSACK for TO_CYCLES = 64: ERROR on clock 64 of DATA. Expect ERR = 1, no F2CPU pulse, no DONE, and BGACK_ = 1 one clock later. ERR clears after DMAENA = 0.
- BERR_ low on the 2nd DATA clock of the 3rd burst word: ERROR; the earlier 2 words produced 2 strobes.
- RST_ pulled low in DATA: AS_, DS_, BGACK_ and BREQ_ go to 1 asynchronously. After release, the block starts again only from IDLE with a fresh BREQ_.

Source files
------------

// File: rtl/cpu_dma_pkg.sv
// Shared types and encodings for the CPU-side DMA bus-master state machine.
package cpu_dma_pkg;

    typedef enum logic [3:0] {
        IDLE,
        BREQ,
        OWN,
        ADDR,
        DATA,
        TERM,
        TERM16,
        ERROR,
        RELEASE
    } dma_state_t;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_WORD = 2'b10;

    // DSACK decode, ordered as {DSACK1_, DSACK0_}
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

endpackage

// File: rtl/cpu_dma_bus_sm_if.sv
// 68030 bus-side signals of the DMA master: arbitration, strobes, sizing and termination.
interface cpu_dma_bus_sm_if;
    logic       BGRANT_;
    logic       DSACK0_;
    logic       DSACK1_;
    logic       BERR_;
    logic       BREQ_;
    logic       BGACK_;
    logic       AS_;
    logic       DS_;
    logic       RW;
    logic [1:0] SIZ;

    modport master (
        input  BGRANT_, DSACK0_, DSACK1_, BERR_,
        output BREQ_, BGACK_, AS_, DS_, RW, SIZ
    );

    modport slave (
        output BGRANT_, DSACK0_, DSACK1_, BERR_,
        input  BREQ_, BGACK_, AS_, DS_, RW, SIZ
    );
endinterface

// File: rtl/cpu_dma_timeout.sv
// Data-phase watchdog: loadable up-counter with clear and enable, flags when it reaches LIMIT.
module cpu_dma_timeout #(
    parameter int TO_WIDTH = 8,
    parameter int LIMIT    = 63
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                load,
    input  logic [TO_WIDTH-1:0] load_val,
    output logic                expired
);
    logic [TO_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == LIMIT[TO_WIDTH-1:0]);
endmodule

// File: rtl/cpu_dma_bus_sm.sv
// CPU-side DMA bus master: arbitrates for the 68030 bus and runs long/word bursts
// between the FIFO and memory with port sizing, burst limit, timeout and bus-error exit.
module cpu_dma_bus_sm
    import cpu_dma_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int TO_CYCLES = 64,
    parameter int TO_WIDTH  = 8
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic             DMAENA,
    input  logic             DMADIR,
    input  logic             FIFOEMPTY,
    input  logic             FIFOFULL,
    input  logic             FLUSHFIFO,
    input  logic             LASTWORD,
    input  logic             BOEQ3,
    input  logic             A1,
    cpu_dma_bus_sm_if.master bus,
    output logic             F2CPU,
    output logic             CPU2F,
    output logic             INCNO_L,
    output logic             INCNO_W,
    output logic             DONE,
    output logic             ERR
);
    dma_state_t state_reg, state_next;
    logic       dir_reg;
    logic       half_reg;
    logic       lw_reg;
    logic       err_reg;
    logic [1:0] siz_reg;
    logic [3:0] burst_reg;

    logic       start_ok, avail, more, to_expired;
    logic [1:0] siz_addr, dsack;

    cpu_dma_timeout #(
        .TO_WIDTH (TO_WIDTH),
        .LIMIT    (TO_CYCLES - 1)
    ) u_timeout (
        .clk      (CLK),
        .rst_n    (RST_),
        .clr      (state_reg == ADDR),
        .en       (state_reg == DATA),
        .load     (1'b0),
        .load_val ({TO_WIDTH{1'b0}}),
        .expired  (to_expired)
    );

    always_comb begin
        start_ok = DMAENA & ~err_reg &
                   (DMADIR ? (FIFOFULL | (FLUSHFIFO & ~FIFOEMPTY) | (FLUSHFIFO & LASTWORD))
                           : ~FIFOFULL);
        // the second half of a long on a 16-bit port is always a word
        siz_addr = (half_reg | A1 | (dir_reg & LASTWORD & ~BOEQ3)) ? SIZ_WORD : SIZ_LONG;
        avail    = dir_reg ? (~FIFOEMPTY | LASTWORD) : ~FIFOFULL;
        more     = (({1'b0, burst_reg} + 5'd1) < BURST_MAX[4:0]) & DMAENA & avail & ~lw_reg;
        dsack    = {bus.DSACK1_, bus.DSACK0_};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = BREQ;
            BREQ:    if (!bus.BGRANT_) state_next = OWN;
            OWN:     state_next = ADDR;
            ADDR:    state_next = DATA;
            DATA: begin
                if (!bus.BERR_ || to_expired) begin
                    state_next = ERROR;
                end else begin
                    case (dsack)
                        DSACK_32:   state_next = TERM;
                        DSACK_16:   state_next = (siz_reg == SIZ_LONG) ? TERM16 : TERM;
                        DSACK_8:    state_next = ERROR;
                        DSACK_NONE: state_next = DATA;
                        default:    state_next = DATA;
                    endcase
                end
            end
            TERM:    state_next = more ? ADDR : RELEASE;
            TERM16:  state_next = ADDR;
            ERROR:   state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_reg <= IDLE;
            dir_reg   <= 1'b0;
            half_reg  <= 1'b0;
            lw_reg    <= 1'b0;
            err_reg   <= 1'b0;
            siz_reg   <= SIZ_LONG;
            burst_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start_ok) dir_reg <= DMADIR;
            if (state_reg == ADDR) begin
                siz_reg <= siz_addr;
                if (!half_reg) lw_reg <= dir_reg & LASTWORD;
            end
            if (state_reg == TERM16) begin
                half_reg <= 1'b1;
            end else if (state_reg == TERM || state_reg == ERROR) begin
                half_reg <= 1'b0;
            end
            if (state_reg == TERM) begin
                burst_reg <= burst_reg + 4'd1;
            end else if (state_reg == RELEASE) begin
                burst_reg <= 4'd0;
            end
            if (state_reg == ERROR) begin
                err_reg <= 1'b1;
            end else if (!DMAENA) begin
                err_reg <= 1'b0;
            end
        end
    end

    // Moore decode so an asynchronous reset drops every strobe at once
    always_comb begin
        bus.BREQ_  = (state_reg != BREQ);
        bus.BGACK_ = !(state_reg inside {OWN, ADDR, DATA, TERM, TERM16, ERROR});
        bus.AS_    = !(state_reg inside {ADDR, DATA});
        bus.DS_    = (state_reg != DATA);
        bus.RW     = (state_reg inside {ADDR, DATA, TERM, TERM16}) ? ~dir_reg : 1'b1;
        bus.SIZ    = SIZ_LONG;
        if (state_reg == ADDR) begin
            bus.SIZ = siz_addr;
        end else if (state_reg inside {DATA, TERM, TERM16, ERROR}) begin
            bus.SIZ = siz_reg;
        end
        F2CPU   = (state_reg == TERM) & dir_reg;
        CPU2F   = (state_reg == TERM) & ~dir_reg;
        INCNO_L = (state_reg == TERM) & (siz_reg == SIZ_LONG);
        INCNO_W = ((state_reg == TERM) & (siz_reg == SIZ_WORD)) | (state_reg == TERM16);
        // ERR is already set during the RELEASE that follows ERROR, which suppresses DONE
        DONE    = (state_reg == RELEASE) & ~err_reg;
        ERR     = err_reg;
    end
endmodule
